// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one single-ported RAM between the icache (read-only) and the dcache
//   (read/write). One requester is granted per RAM transaction. The grant is
//   held until the RAM reports ACCESS or the requester withdraws. The
//   ungranted cache always sees wait=1 and load=0.
//
// Optional feature:
//   MEM_ARBITER_STARVE_GUARD_EN  when defined, the icache is forced a grant
//                                after STARVE_LIMIT consecutive dcache grants
//                                issued while iREN was pending. When undefined,
//                                the dcache has strict priority.
//
// Ports
//   CLK, nRST          clock (rising edge), asynchronous active-low reset
//   iREN, iaddr        icache read request and address
//   iwait, iload       icache stall (0 only in its ACCESS cycle) and read data
//   dREN, dWEN         dcache read / write request (both high is a write)
//   daddr, dstore      dcache address and write data
//   dwait, dload       dcache stall (0 only in its ACCESS cycle) and read data
//   ramREN, ramWEN     RAM read / write enable
//   ramaddr, ramstore  RAM address and write data
//   ramload, ramstate  RAM read data and status (FREE=0 BUSY=1 ACCESS=2 ERROR=3)
//
// state  | meaning
// IDLE   | no RAM enables; picks the next requester (costs one cycle)
// DGRANT | dcache owns the RAM until ACCESS or withdraw
// IGRANT | icache owns the RAM until ACCESS or withdraw

module mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              iwait,
    output logic [DATA_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              dwait,
    output logic [DATA_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic [1:0]        ramstate
);

    localparam logic [1:0] RAM_ACCESS = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DGRANT = 2'd1,
        IGRANT = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic d_req;
    logic starve;

    assign d_req = dREN | dWEN;

    if (STARVE_LIMIT < 1) begin : g_bad_limit
        $error("mem_arbiter: STARVE_LIMIT must be at least 1");
    end

`ifdef MEM_ARBITER_STARVE_GUARD_EN
    localparam int CNT_W = ($clog2(STARVE_LIMIT + 1) > 3) ? $clog2(STARVE_LIMIT + 1) : 3;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] dstreak;

    assign starve = iREN && (dstreak == LIMIT);

    // Only IDLE decisions touch the streak; it saturates at LIMIT.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            dstreak <= '0;
        end else if (state == IDLE) begin
            if (!iREN || (next_state == IGRANT)) begin
                dstreak <= '0;
            end else if ((next_state == DGRANT) && (dstreak != LIMIT)) begin
                dstreak <= dstreak + 1'b1;
            end
        end
    end
`else
    assign starve = 1'b0;
`endif

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // All outputs decode from the state. Reset forces IDLE at once, so the
    // RAM enables drop while nRST is still low.
    always_comb begin
        next_state = state;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = '0;
        ramstore   = '0;
        iwait      = 1'b1;
        dwait      = 1'b1;
        iload      = '0;
        dload      = '0;

        case (state)
            IDLE: begin
                if (starve) begin
                    next_state = IGRANT;
                end else if (d_req) begin
                    next_state = DGRANT;
                end else if (iREN) begin
                    next_state = IGRANT;
                end
            end

            DGRANT: begin
                ramREN   = dREN & ~dWEN;
                ramWEN   = dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                dload    = ramload;
                if (!d_req) begin
                    next_state = IDLE;
                end else if (ramstate == RAM_ACCESS) begin
                    dwait      = 1'b0;
                    next_state = IDLE;
                end
            end

            IGRANT: begin
                ramREN  = iREN;
                ramaddr = iaddr;
                iload   = ramload;
                if (!iREN) begin
                    next_state = IDLE;
                end else if (ramstate == RAM_ACCESS) begin
                    iwait      = 1'b0;
                    next_state = IDLE;
                end
            end

            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule
